// File: rtl/ucnt_sweep_ctrl.sv
// ucnt_sweep_ctrl
//   Command sequencer for the 8-bit universal up/down counter. It drives the
//   counter's active-low controls so that the counter sweeps lo -> hi, dwells,
//   sweeps hi -> lo and dwells again. An internal mirror tracks the counter
//   value, so no feedback from the counter is needed.
//
//   Optional build macro: UCS_REPEAT_EN adds the reps input. With it the sweep
//   repeats reps times (reps = 0 repeats until stop/clr_req).
//
// Ports
//   clk      system clock, rising edge
//   rstb     asynchronous active-low reset
//   start    pulse; begins a sweep when idle and lo <= hi
//   stop     abort; counter holds, return to idle
//   clr_req  abort plus one-cycle counter clear (highest priority)
//   lo, hi   sweep bounds, sampled on accepted start
//   dwell    hold cycles at each end, sampled on accepted start
//   reps     (UCS_REPEAT_EN only) sweep count, sampled on accepted start
//   clrb, ldb, hdb, upb, d   counter command (registered)
//   mirror   counter value after the current command is applied
//   busy     sweep in progress
//   done     one-cycle pulse at normal completion
//   err      one-cycle pulse on rejected start (lo > hi)
module ucnt_sweep_ctrl #(
    parameter int W  = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          start,
    input  logic          stop,
    input  logic          clr_req,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [DW-1:0] dwell,
`ifdef UCS_REPEAT_EN
    input  logic [7:0]    reps,
`endif
    output logic          clrb,
    output logic          ldb,
    output logic          hdb,
    output logic          upb,
    output logic [W-1:0]  d,
    output logic [W-1:0]  mirror,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO,
        FIN
    } state_t;

    state_t        state, ns;
    logic [W-1:0]  lo_q, hi_q, n_lo, n_hi;
    logic [DW-1:0] dwell_q, n_dwell;
    logic [DW-1:0] timer, n_timer;
    logic          n_clrb, n_ldb, n_hdb, n_upb;
    logic [W-1:0]  n_d, n_mirror;
    state_t        top_state;
`ifdef UCS_REPEAT_EN
    logic [7:0]    reps_q, n_reps, sweeps, n_sweeps;
`endif

    // State at the top of a sweep (after LOAD, or when a repeat restarts)
    always_comb begin
        if (hi_q > lo_q)
            top_state = UP;
        else if (dwell_q != '0)
            top_state = HOLD_HI;
        else
            top_state = FIN;
    end

    // Next state and next command; the command is derived from the next state
    // so that every output is registered together with the state.
    always_comb begin
        ns       = state;
        n_lo     = lo_q;
        n_hi     = hi_q;
        n_dwell  = dwell_q;
        n_timer  = timer;
        n_clrb   = 1'b1;
        n_ldb    = 1'b1;
        n_hdb    = 1'b0;
        n_upb    = 1'b1;
        n_d      = '0;
        n_mirror = mirror;
`ifdef UCS_REPEAT_EN
        n_reps   = reps_q;
        n_sweeps = sweeps;
`endif

        case (state)
            IDLE: begin
                if (start && !stop && lo <= hi) begin
                    ns      = LOAD;
                    n_lo    = lo;
                    n_hi    = hi;
                    n_dwell = dwell;
`ifdef UCS_REPEAT_EN
                    n_reps   = reps;
                    n_sweeps = '0;
`endif
                end
            end
            LOAD:    ns = top_state;
            UP:      if (mirror == hi_q) ns = (dwell_q != '0) ? HOLD_HI : DOWN;
            HOLD_HI: if (timer <= DW'(1)) ns = (hi_q != lo_q) ? DOWN : HOLD_LO;
            DOWN, HOLD_LO: begin
                // End of one full sweep: either at the low bound with no
                // dwell, or when the low dwell expires.
                if ((state == DOWN && mirror == lo_q && dwell_q == '0) ||
                    (state == HOLD_LO && timer <= DW'(1))) begin
`ifdef UCS_REPEAT_EN
                    if (reps_q != '0 && sweeps == reps_q - 8'd1) begin
                        ns = FIN;
                    end else begin
                        ns       = top_state;
                        n_sweeps = sweeps + 8'd1;
                    end
`else
                    ns = FIN;
`endif
                end else if (state == DOWN && mirror == lo_q) begin
                    ns = HOLD_LO;
                end
            end
            FIN:     ns = IDLE;
            default: ns = IDLE;
        endcase

        if (clr_req || (stop && state != IDLE))
            ns = IDLE;

        // Dwell timer: loaded on entry to a hold state, counts down to 1
        if ((ns == HOLD_HI || ns == HOLD_LO) && ns != state)
            n_timer = dwell_q;
        else if ((ns == HOLD_HI || ns == HOLD_LO) && timer > DW'(1))
            n_timer = timer - DW'(1);

        case (ns)
            LOAD: begin
                n_ldb = 1'b0;
                n_d   = n_lo;
            end
            UP: begin
                n_hdb = 1'b1;
                n_upb = 1'b0;
            end
            DOWN: begin
                n_hdb = 1'b1;
                n_upb = 1'b1;
            end
            default: ;
        endcase

        if (clr_req)
            n_clrb = 1'b0;

        // Counter priority: clear > load > hold > count
        if (!n_clrb)
            n_mirror = '0;
        else if (!n_ldb)
            n_mirror = n_d;
        else if (!n_hdb)
            n_mirror = mirror;
        else if (n_upb)
            n_mirror = mirror - W'(1);
        else
            n_mirror = mirror + W'(1);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
            timer   <= '0;
            clrb    <= 1'b1;
            ldb     <= 1'b1;
            hdb     <= 1'b0;
            upb     <= 1'b1;
            d       <= '0;
            mirror  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef UCS_REPEAT_EN
            reps_q  <= '0;
            sweeps  <= '0;
`endif
        end else begin
            state   <= ns;
            lo_q    <= n_lo;
            hi_q    <= n_hi;
            dwell_q <= n_dwell;
            timer   <= n_timer;
            clrb    <= n_clrb;
            ldb     <= n_ldb;
            hdb     <= n_hdb;
            upb     <= n_upb;
            d       <= n_d;
            mirror  <= n_mirror;
            busy    <= (ns != IDLE) && (ns != FIN);
            done    <= (ns == FIN);
            err     <= (state == IDLE) && start && !stop && !clr_req && (lo > hi);
`ifdef UCS_REPEAT_EN
            reps_q  <= n_reps;
            sweeps  <= n_sweeps;
`endif
        end
    end

endmodule
